// File: rtl/mux_pkg.sv
// Shared definitions for the N:1 registered scan multiplexer.
package mux_pkg;

  localparam logic MODE_STATIC = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Width needed to index n items. It never returns 0, so a single-item
  // range still gets a 1-bit field.
  function automatic int clog2_safe(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_scan_ctr.sv
// Round-robin scan pointer with a per-channel dwell counter.
module mux_scan_ctr
  import mux_pkg::*;
#(
  parameter int NCH   = 8,
  parameter int DWELL = 1,
  parameter int SELW  = clog2_safe(NCH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            step,
  input  logic            clr,
  output logic [SELW-1:0] ptr
);

  localparam int                DCW   = clog2_safe(DWELL);
  localparam logic [DCW-1:0]    DLAST = DCW'(DWELL - 1);
  localparam logic [SELW-1:0]   PLAST = SELW'(NCH - 1);

  logic [DCW-1:0] dcnt;

  // Advance the pointer after DWELL accepted samples; hold on stalls; restart on clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr  <= '0;
      dcnt <= '0;
    end else if (clr) begin
      ptr  <= '0;
      dcnt <= '0;
    end else if (step) begin
      if (dcnt == DLAST) begin
        dcnt <= '0;
        ptr  <= (ptr == PLAST) ? '0 : ptr + SELW'(1);
      end else begin
        dcnt <= dcnt + DCW'(1);
      end
    end
  end

endmodule

// File: rtl/mux_nx1_scan.sv
// N-channel, W-bit registered multiplexer with static select or round-robin
// auto-scan, and a valid/ready output handshake.
module mux_nx1_scan
  import mux_pkg::*;
#(
  parameter int NCH   = 8,
  parameter int W     = 8,
  parameter int DWELL = 1,
  parameter int SELW  = clog2_safe(NCH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH*W-1:0]  in_data,
  input  logic [SELW-1:0]   sel,
  input  logic              mode,
  input  logic              en,
  output logic [W-1:0]      out_data,
  output logic [SELW-1:0]   out_sel,
  output logic              out_valid,
  input  logic              out_ready
);

  // Out-of-range static selects (only possible for non-power-of-2 NCH)
  // collapse onto the last channel.
  function automatic logic [SELW-1:0] clamp_sel(input logic [SELW-1:0] s);
    if ({1'b0, s} >= (SELW+1)'(NCH))
      return SELW'(NCH - 1);
    return s;
  endfunction

  logic [W-1:0]    ch [NCH];
  logic [SELW-1:0] ptr;
  logic            cap_p0;
  logic [SELW-1:0] chan_p0;
  logic [W-1:0]    data_p0;
  logic [W-1:0]    data_p1;
  logic [SELW-1:0] sel_p1;
  logic            vld_p1;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    assign ch[k] = in_data[k*W +: W];
  end

  // Load when empty or when the held sample is consumed this cycle.
  assign cap_p0 = en & (~vld_p1 | out_ready);

  mux_scan_ctr #(
    .NCH   (NCH),
    .DWELL (DWELL),
    .SELW  (SELW)
  ) u_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .step  ((mode == MODE_SCAN) & cap_p0),
    .clr   (mode == MODE_STATIC),
    .ptr   (ptr)
  );

  // Pick the channel index and its data for this cycle's capture.
  always_comb begin
    chan_p0 = (mode == MODE_SCAN) ? ptr : clamp_sel(sel);
    data_p0 = '0;
    for (int k = 0; k < NCH; k++) begin
      if (chan_p0 == SELW'(k))
        data_p0 = ch[k];
    end
  end

  // ---- stage p0 -> p1: output register and handshake ----
  // Output register; contents stay frozen while the sample is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_p1 <= '0;
      sel_p1  <= '0;
      vld_p1  <= 1'b0;
    end else begin
      if (cap_p0) begin
        data_p1 <= data_p0;
        sel_p1  <= chan_p0;
      end
      if (cap_p0)
        vld_p1 <= 1'b1;
      else if (out_ready)
        vld_p1 <= 1'b0;
    end
  end

  assign out_data  = data_p1;
  assign out_sel   = sel_p1;
  assign out_valid = vld_p1;

endmodule

// File: tb/tb_mux_nx1_scan.sv
module tb_mux_nx1_scan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] in8;
  logic [47:0] in6;
  logic [2:0]  sel;
  logic        mode, en, out_ready;

  logic [7:0] a_data, b_data, c_data;
  logic [2:0] a_sel, b_sel, c_sel;
  logic       a_vld, b_vld, c_vld;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // a: NCH=8 DWELL=1, b: NCH=8 DWELL=2, c: NCH=6 DWELL=1
  mux_nx1_scan #(.NCH(8), .W(8), .DWELL(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(in8), .sel(sel), .mode(mode), .en(en),
    .out_data(a_data), .out_sel(a_sel), .out_valid(a_vld), .out_ready(out_ready));
  mux_nx1_scan #(.NCH(8), .W(8), .DWELL(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(in8), .sel(sel), .mode(mode), .en(en),
    .out_data(b_data), .out_sel(b_sel), .out_valid(b_vld), .out_ready(out_ready));
  mux_nx1_scan #(.NCH(6), .W(8), .DWELL(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_data(in6), .sel(sel), .mode(mode), .en(en),
    .out_data(c_data), .out_sel(c_sel), .out_valid(c_vld), .out_ready(out_ready));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_in(input logic [7:0] base);
    for (int k = 0; k < 8; k++) in8[k*8 +: 8] = base + 8'(k);
    for (int k = 0; k < 6; k++) in6[k*8 +: 8] = 8'h30 + 8'(k);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in8 = {$urandom, $urandom};
    in6 = {16'($urandom), $urandom};
    sel = 3'($urandom); mode = 1'($urandom); en = 1'b1; out_ready = 1'($urandom);
    repeat (3) step();
    checks++;
    if (a_vld !== 1'b0 || a_data !== 8'h00 || a_sel !== 3'd0) begin
      errors++;
      $display("FAIL reset_hold got vld=%b data=%h sel=%0d exp 0/00/0", a_vld, a_data, a_sel);
    end
    rst_n = 1'b1;
    load_in(8'h10);
    mode = 1'b0; sel = 3'd6; out_ready = 1'b0;
    step();
    step();
    checks++;
    if (a_vld !== 1'b1 || a_data !== 8'h16) begin
      errors++;
      $display("FAIL pre_reset_load got vld=%b data=%h exp 1/16", a_vld, a_data);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (a_vld !== 1'b0 || a_data !== 8'h00 || a_sel !== 3'd0 ||
        b_vld !== 1'b0 || c_vld !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got vld=%b data=%h sel=%0d bv=%b cv=%b exp all 0",
               a_vld, a_data, a_sel, b_vld, c_vld);
    end
    step();
    rst_n = 1'b1;
    en = 1'b0; out_ready = 1'b1;
    step();
  endtask

  task automatic test_static();
    mode = 1'b0; en = 1'b1; out_ready = 1'b1;
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      step();
      checks++;
      if (a_data !== 8'h10 + 8'(s) || a_sel !== 3'(s) || a_vld !== 1'b1) begin
        errors++;
        $display("FAIL static s=%0d got data=%h sel=%0d vld=%b exp %h/%0d/1",
                 s, a_data, a_sel, a_vld, 8'h10 + 8'(s), s);
      end
    end
  endtask

  task automatic test_backpressure();
    mode = 1'b0; en = 1'b1; out_ready = 1'b1; sel = 3'd3;
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sel = 3'(6 - i);
      load_in(8'hA0 + 8'(i << 4));
      step();
      checks++;
      if (a_data !== 8'h13 || a_sel !== 3'd3 || a_vld !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold i=%0d got data=%h sel=%0d vld=%b exp 13/3/1",
                 i, a_data, a_sel, a_vld);
      end
    end
    load_in(8'hA0);
    sel = 3'd6; out_ready = 1'b1;
    step();
    checks++;
    if (a_data !== 8'hA6 || a_sel !== 3'd6 || a_vld !== 1'b1) begin
      errors++;
      $display("FAIL bp_release got data=%h sel=%0d vld=%b exp a6/6/1", a_data, a_sel, a_vld);
    end
    load_in(8'h10);
  endtask

  task automatic test_scan_dwell2();
    mode = 1'b0; en = 1'b1; out_ready = 1'b1;
    step();
    mode = 1'b1;
    for (int i = 0; i < 18; i++) begin
      step();
      checks++;
      if (b_sel !== 3'((i / 2) % 8) || b_data !== 8'h10 + 8'((i / 2) % 8) || b_vld !== 1'b1) begin
        errors++;
        $display("FAIL scan_dwell2 i=%0d got sel=%0d data=%h vld=%b exp %0d", i, b_sel, b_data,
                 b_vld, (i / 2) % 8);
      end
    end
  endtask

  task automatic test_scan_stall();
    mode = 1'b0; en = 1'b1; out_ready = 1'b1;
    step();
    mode = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (a_sel !== 3'(i)) begin
        errors++;
        $display("FAIL stall_lead i=%0d got sel=%0d exp %0d", i, a_sel, i);
      end
    end
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (a_sel !== 3'd5 || a_data !== 8'h15 || a_vld !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold i=%0d got sel=%0d data=%h exp 5/15", i, a_sel, a_data);
      end
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (a_sel !== 3'((6 + i) % 8) || a_data !== 8'h10 + 8'((6 + i) % 8)) begin
        errors++;
        $display("FAIL stall_resume i=%0d got sel=%0d data=%h exp %0d", i, a_sel, a_data,
                 (6 + i) % 8);
      end
    end
  endtask

  task automatic test_reentry();
    mode = 1'b0; en = 1'b1; out_ready = 1'b1;
    step();
    mode = 1'b1;
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (a_sel !== 3'd4) begin
      errors++;
      $display("FAIL reentry_lead got sel=%0d exp 4", a_sel);
    end
    mode = 1'b0; sel = 3'd2;
    step();
    checks++;
    if (a_sel !== 3'd2 || a_data !== 8'h12) begin
      errors++;
      $display("FAIL reentry_static got sel=%0d data=%h exp 2/12", a_sel, a_data);
    end
    mode = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (a_sel !== 3'(i) || a_data !== 8'h10 + 8'(i)) begin
        errors++;
        $display("FAIL reentry_scan i=%0d got sel=%0d data=%h exp %0d", i, a_sel, a_data, i);
      end
    end
  endtask

  task automatic test_out_of_range();
    logic [2:0] sv [3];
    logic [2:0] ev [3];
    sv = '{3'd7, 3'd6, 3'd4};
    ev = '{3'd5, 3'd5, 3'd4};
    mode = 1'b0; en = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sel = sv[i];
      step();
      checks++;
      if (c_sel !== ev[i] || c_data !== 8'h30 + 8'(ev[i])) begin
        errors++;
        $display("FAIL oor sel=%0d got sel=%0d data=%h exp %0d/%h", sv[i], c_sel, c_data,
                 ev[i], 8'h30 + 8'(ev[i]));
      end
    end
  endtask

  task automatic test_drain();
    mode = 1'b0; sel = 3'd1; en = 1'b1; out_ready = 1'b1;
    step();
    en = 1'b0; out_ready = 1'b0; sel = 3'd2;
    step();
    checks++;
    if (a_vld !== 1'b1 || a_data !== 8'h11) begin
      errors++;
      $display("FAIL drain_hold got vld=%b data=%h exp 1/11", a_vld, a_data);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (a_vld !== 1'b0 || a_data !== 8'h11) begin
      errors++;
      $display("FAIL drain_empty got vld=%b data=%h exp 0/11", a_vld, a_data);
    end
    en = 1'b1;
    step();
    checks++;
    if (a_vld !== 1'b1 || a_data !== 8'h12) begin
      errors++;
      $display("FAIL drain_refill got vld=%b data=%h exp 1/12", a_vld, a_data);
    end
  endtask

  initial begin
    test_reset();
    test_static();
    test_backpressure();
    test_scan_dwell2();
    test_scan_stall();
    test_reentry();
    test_out_of_range();
    test_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
